gate_sweep_ctrl: RTL

//  Drives the two inputs (a, b) of a 2-input combinational gate through all four

---
 rtl/gate_sweep_ctrl_if.sv | 23 ++
 rtl/gate_sweep_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl_if.sv
// Stimulus/capture bundle between the sweep controller and the gate under test.
// master = controller side, slave = gate/host side.
interface gate_sweep_ctrl_if;
  logic       start;
  logic [3:0] expect_tt;
  logic       z;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic [3:0] tt;
  logic       pass;

  modport master (
    input  start, expect_tt, z,
    output a, b, busy, done, tt, pass
  );

  modport slave (
    output start, expect_tt, z,
    input  a, b, busy, done, tt, pass
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Sweeps {a,b} through 00..11, holding each HOLD_CYCLES cycles, captures z at the
// end of each hold into a truth table and compares it with a latched expectation.
module gate_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  gate_sweep_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx,   w_idx_nxt;
  logic [1:0]       r_ab,    w_ab_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [3:0]       r_exp,   w_exp_nxt;
  logic [3:0]       r_tt,    w_tt_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_pass,  w_pass_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ab    <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_tt    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ab    <= w_ab_nxt;
      r_cnt   <= w_cnt_nxt;
      r_exp   <= w_exp_nxt;
      r_tt    <= w_tt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ab_nxt    = r_ab;
    w_cnt_nxt   = r_cnt;
    w_exp_nxt   = r_exp;
    w_tt_nxt    = r_tt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_exp_nxt   = bus.expect_tt;
          w_idx_nxt   = '0;
          w_ab_nxt    = '0;
          w_cnt_nxt   = '0;
          w_tt_nxt    = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_state_nxt = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (r_cnt != CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_tt_nxt[r_idx] = bus.z;
          if (r_idx != 2'd3) begin
            w_idx_nxt = r_idx + 2'd1;
            w_ab_nxt  = r_idx + 2'd1;
            w_cnt_nxt = '0;
          end else begin
            // Final sample is still in flight, so compare using z directly.
            w_pass_nxt  = ({bus.z, r_tt[2:0]} == r_exp);
            w_ab_nxt    = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.a    = r_ab[1];
  assign bus.b    = r_ab[0];
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.tt   = r_tt;
  assign bus.pass = r_pass;

endmodule
